// File: rtl/uart_frame_controller.sv
// rtl/uart_frame_controller.sv - framed UART byte receiver with checksum, timeout and drain stream
module uart_frame_controller #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         MAX_LEN     = 16,
   parameter int         TIMEOUT_CYC = 200000
) (
   input  logic       system_clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_done,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] frame_len,
   output logic       frame_ok,
   output logic [1:0] err_code,
   output logic       overrun,
   input  logic       err_clr
);

   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHECK, S_DRAIN} state_t;

   state_t        state, state_nx;
   logic [7:0]    len;
   logic [7:0]    xsum;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] rd_nxt;
   logic [TW-1:0] tcnt;
   logic [7:0]    mem [0:(1<<AW)-1];
   logic          busy, tmo, len_bad, chk_ok, last_wr, last_rd, take;
   logic [1:0]    err_new;

   assign busy    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHECK);
   // An arriving byte always beats an expiring timeout in the same cycle.
   assign tmo     = busy && !rx_done && (tcnt == TW'(TIMEOUT_CYC));
   assign len_bad = (rx_byte == 8'd0) || (int'(rx_byte) > MAX_LEN);
   assign chk_ok  = (rx_byte == xsum);
   assign last_wr = (wr_idx == AW'(len - 8'd1));
   assign last_rd = (rd_idx == AW'(len - 8'd1));
   assign rd_nxt  = rd_idx + AW'(1);
   assign take    = out_valid && out_ready;

   always_comb begin
      state_nx = state;
      err_new  = 2'd0;
      case (state)
         S_IDLE: begin
            if (rx_done && rx_byte == SYNC_BYTE) state_nx = S_LEN;
         end
         S_LEN: begin
            if (rx_done) begin
               if (len_bad) begin
                  state_nx = S_IDLE;
                  err_new  = 2'd1;
               end else begin
                  state_nx = S_PAYLOAD;
               end
            end else if (tmo) begin
               state_nx = S_IDLE;
               err_new  = 2'd3;
            end
         end
         S_PAYLOAD: begin
            if (rx_done) begin
               if (last_wr) state_nx = S_CHECK;
            end else if (tmo) begin
               state_nx = S_IDLE;
               err_new  = 2'd3;
            end
         end
         S_CHECK: begin
            if (rx_done) begin
               if (chk_ok) begin
                  state_nx = S_DRAIN;
               end else begin
                  state_nx = S_IDLE;
                  err_new  = 2'd2;
               end
            end else if (tmo) begin
               state_nx = S_IDLE;
               err_new  = 2'd3;
            end
         end
         S_DRAIN: begin
            if (take && last_rd) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge system_clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         len       <= 8'd0;
         xsum      <= 8'd0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         tcnt      <= '0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
         frame_len <= 8'd0;
         frame_ok  <= 1'b0;
         err_code  <= 2'd0;
         overrun   <= 1'b0;
      end else begin
         state    <= state_nx;
         frame_ok <= 1'b0;
         tcnt     <= (busy && !rx_done) ? tcnt + TW'(1) : '0;
         case (state)
            S_LEN: begin
               if (rx_done) begin
                  len    <= rx_byte;
                  xsum   <= rx_byte;
                  wr_idx <= '0;
               end
            end
            S_PAYLOAD: begin
               if (rx_done) begin
                  xsum   <= xsum ^ rx_byte;
                  wr_idx <= wr_idx + AW'(1);
               end
            end
            S_CHECK: begin
               if (rx_done && chk_ok) begin
                  frame_ok  <= 1'b1;
                  frame_len <= len;
                  out_valid <= 1'b1;
                  out_data  <= mem[0];
                  rd_idx    <= '0;
               end
            end
            S_DRAIN: begin
               if (take) begin
                  if (last_rd) begin
                     out_valid <= 1'b0;
                     out_data  <= 8'd0;
                     frame_len <= 8'd0;
                  end else begin
                     rd_idx   <= rd_nxt;
                     out_data <= mem[rd_nxt];
                  end
               end
            end
            default: ;
         endcase
         if (err_new != 2'd0) err_code <= err_new;
         else if (err_clr)    err_code <= 2'd0;
         if (state == S_DRAIN && rx_done) overrun <= 1'b1;
         else if (err_clr)                overrun <= 1'b0;
      end
   end

   always_ff @(posedge system_clk) begin
      if (state == S_PAYLOAD && rx_done) mem[wr_idx] <= rx_byte;
   end

endmodule

// File: tb/tb_uart_frame_controller.sv
// tb/tb_uart_frame_controller.sv - randomized scoreboard bench for uart_frame_controller
module tb_uart_frame_controller;

   localparam int MAX_LEN = 16;
   localparam int TMO     = 60;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rx_byte = 8'd0;
   logic       rx_done = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] frame_len;
   logic       frame_ok;
   logic [1:0] err_code;
   logic       overrun;
   logic       err_clr = 1'b0;

   int errors = 0;
   int checks = 0;
   int ready_mode = 1;
   logic [7:0] exp_q [$];
   int         ok_q  [$];
   logic [7:0] pl [256];
   logic [1:0] exp_err = 2'd0;
   logic       prev_v = 1'b0, prev_r = 1'b0;
   logic [7:0] prev_d = 8'd0;

   uart_frame_controller #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
      .system_clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_done(rx_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_len(frame_len), .frame_ok(frame_ok), .err_code(err_code),
      .overrun(overrun), .err_clr(err_clr));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         prev_v = 1'b0;
      end else begin
         if (prev_v && !prev_r) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_d);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL out_extra actual=%0h required=none", out_data);
            end else chk("out_data", out_data, exp_q.pop_front());
         end
         if (frame_ok) begin
            if (ok_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ok_extra actual=1 required=0");
            end else chk("ok_frame_len", frame_len, ok_q.pop_front());
         end
         prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_byte = b; rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1; err_clr = 1'b1;
      @(posedge clk); #1; err_clr = 1'b0;
      exp_err = 2'd0;
      chk("clr_err", err_code, 0);
      chk("clr_overrun", overrun, 0);
   endtask

   // Reference: a frame is good iff 1<=n<=MAX_LEN and the checksum byte is the XOR of n and payload.
   task automatic run_frame(input int n, input bit corrupt);
      logic [7:0] c;
      c = 8'(n);
      for (int i = 0; i < n; i++) c ^= pl[i];
      if (corrupt) c ^= 8'($urandom_range(1, 255));
      send_byte(8'hA5);
      if (n == 0 || n > MAX_LEN) begin
         send_byte(8'(n));
         exp_err = 2'd1;
         chk("badlen_noack", frame_ok, 0);
      end else begin
         if (!corrupt) begin
            for (int i = 0; i < n; i++) exp_q.push_back(pl[i]);
            ok_q.push_back(n);
         end else exp_err = 2'd2;
         send_byte(8'(n));
         for (int i = 0; i < n; i++) send_byte(pl[i]);
         send_byte(c);
         chk("frame_ok_timing", frame_ok, !corrupt);
         chk("frame_len_held", frame_len, corrupt ? 0 : n);
      end
      chk("err_code", err_code, exp_err);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      chk("drain_done", (exp_q.size() == 0) && !out_valid, 1);
      chk("len_after_drain", frame_len, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_len", frame_len, 0);
      chk("rst_ok", frame_ok, 0);
      chk("rst_err", err_code, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b1;

      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      run_frame(3, 0);
      wait_idle(50);

      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
      exp_err = 2'd2;
      chk("bad_chk_err", err_code, 2);
      chk("bad_chk_novalid", out_valid, 0);
      pl[0] = 8'h7F;
      run_frame(1, 0);
      chk("single_data", out_data, 8'h7F);
      wait_idle(50);

      run_frame(0, 0);
      pulse_clr();
      run_frame(17, 0);
      pulse_clr();

      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h55);
      repeat (TMO - 5) @(posedge clk);
      #1 chk("tmo_not_early", err_code, 0);
      repeat (10) @(posedge clk);
      #1 chk("tmo_err", err_code, 3);
      exp_err = 2'd3;
      chk("tmo_noframe", out_valid, 0);
      for (int i = 0; i < MAX_LEN; i++) pl[i] = (i % 3 == 0) ? 8'hA5 : 8'($urandom);
      run_frame(MAX_LEN, 0);
      wait_idle(100);

      ready_mode = 0;
      pl[0] = 8'($urandom); pl[1] = 8'($urandom);
      run_frame(2, 0);
      repeat (4) @(posedge clk);
      #1 chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, pl[0]);
      send_byte(8'hA5);
      chk("overrun_set", overrun, 1);
      chk("overrun_data", out_data, pl[0]);
      chk("overrun_len", frame_len, 2);
      ready_mode = 1;
      wait_idle(50);
      pulse_clr();

      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      @(posedge clk); #1 rst = 1'b0;
      #2;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_len", frame_len, 0);
      chk("mid_rst_err", err_code, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      exp_err = 2'd0;
      repeat (5) @(posedge clk);
      #1 chk("post_rst_quiet", out_valid | frame_ok, 0);
      pl[0] = 8'hC3; pl[1] = 8'h3C; pl[2] = 8'h5A;
      run_frame(3, 0);
      wait_idle(50);

      ready_mode = 2;
      for (int f = 0; f < 40; f++) begin
         int n;
         bit bad;
         repeat ($urandom_range(0, 2)) begin
            logic [7:0] g;
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g);
         end
         if ($urandom_range(0, 6) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 40);
         else n = $urandom_range(1, MAX_LEN);
         for (int i = 0; i < n && i < 256; i++) pl[i] = 8'($urandom);
         bad = ($urandom_range(0, 4) == 0);
         run_frame(n, bad);
         wait_idle(400);
      end

      chk("exp_q_empty", exp_q.size(), 0);
      chk("ok_q_empty", ok_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
